// File: rtl/ones_comp_checksum.sv
// Packet checksum engine: folds 4-bit words with end-around-carry addition and
// returns the one's-complement result with a word count and truncation flag.
module ones_comp_checksum #(
  parameter int unsigned MAX_WORDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] out_sum,
  output logic [3:0] out_count,
  output logic       out_trunc,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WORDS);

  state_t     state_q, state_d;
  logic [3:0] acc_q, count_q;
  logic       trunc_q;

  logic [4:0] sum_wide;
  logic [3:0] acc_eac;
  logic [3:0] count_inc;
  logic       take;
  logic       at_limit;
  logic       consume;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = ~acc_q;
  assign out_count = count_q;
  assign out_trunc = trunc_q;

  // acc and count are zero in IDLE, so the same add/increment also loads the first word
  always_comb begin
    sum_wide  = {1'b0, acc_q} + {1'b0, in_data};
    acc_eac   = sum_wide[3:0] + {3'b000, sum_wide[4]};
    count_inc = count_q + 4'd1;
    take      = in_valid && in_ready;
    at_limit  = (count_inc == MAX_W);
    consume   = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (take) begin
          state_d = (in_last || at_limit) ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        acc_q   <= acc_eac;
        count_q <= count_inc;
        trunc_q <= at_limit && !in_last;
      end else if (consume) begin
        acc_q   <= '0;
        count_q <= '0;
        trunc_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ones_comp_checksum.sv
// Scoreboard bench for ones_comp_checksum (MAX_WORDS=4): expected results are
// queued as words are driven and compared when the DUT hands over a result.
module tb_ones_comp_checksum;

  localparam int unsigned MAXW = 4;

  typedef struct packed {
    logic [3:0] sum;
    logic [3:0] cnt;
    logic       trunc;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] out_sum;
  logic [3:0] out_count;
  logic       out_trunc;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  res_t sb[$];

  int m_total = 0;
  int m_cnt = 0;

  ones_comp_checksum #(.MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_trunc(out_trunc),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Result monitor: a handshake is visible mid-cycle before the consuming edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_t got, exp;
      got = '{sum: out_sum, cnt: out_count, trunc: out_trunc};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got sum=%h cnt=%0d trunc=%0b, none expected",
                 out_sum, out_count, out_trunc);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result got sum=%h cnt=%0d trunc=%0b expected sum=%h cnt=%0d trunc=%0b",
                   got.sum, got.cnt, got.trunc, exp.sum, exp.cnt, exp.trunc);
        end
      end
    end
  end

  // Reference: fold the plain integer sum of the packet down to 4 bits
  function automatic logic [3:0] fold_sum(input int total);
    int t;
    t = total;
    while (t > 15) t = (t & 15) + (t >> 4);
    return 4'(t);
  endfunction

  task automatic push_exp(input logic [3:0] s, input logic [3:0] c, input logic t);
    sb.push_back('{sum: s, cnt: c, trunc: t});
  endtask

  // Model step: queue the result this word will close, if any
  task automatic model_word(input logic [3:0] d, input logic l);
    m_total += int'(d);
    m_cnt++;
    if (l || m_cnt == int'(MAXW)) begin
      push_exp(~fold_sum(m_total), 4'(m_cnt), !l);
      m_total = 0;
      m_cnt = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_word(input logic [3:0] d, input logic l);
    logic acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 for %0d cycles expected acceptance", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_model(input logic [3:0] d, input logic l);
    model_word(d, l);
    send_word(d, l);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({out_valid, out_sum, out_count, out_trunc, in_ready} !== {1'b0, 4'hF, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_async got valid=%0b sum=%h cnt=%0d trunc=%0b rdy=%0b expected 0 f 0 0 1",
               out_valid, out_sum, out_count, out_trunc, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_sum, out_count, in_ready} !== {1'b0, 4'hF, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_release got valid=%0b sum=%h cnt=%0d rdy=%0b expected 0 f 0 1",
               out_valid, out_sum, out_count, in_ready);
    end
  endtask

  task automatic test_basic();
    push_exp(4'b0111, 4'd2, 1'b0);
    send_word(4'h3, 1'b0);
    send_word(4'h5, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'b0111) begin
      errors++;
      $display("FAIL latency got valid=%0b sum=%h expected valid=1 sum=7", out_valid, out_sum);
    end
    drain();
  endtask

  task automatic test_carry();
    push_exp(4'b1100, 4'd3, 1'b0);
    send_word(4'hA, 1'b0);
    send_word(4'hB, 1'b0);
    send_word(4'hC, 1'b1);
    push_exp(4'b1110, 4'd2, 1'b0);
    send_word(4'hF, 1'b0);
    send_word(4'h1, 1'b1);
    push_exp(4'b1101, 4'd2, 1'b0);
    send_word(4'h9, 1'b0);
    send_word(4'h8, 1'b1);
    push_exp(4'b1001, 4'd1, 1'b0);
    send_word(4'h6, 1'b1);
    drain();
  endtask

  task automatic test_trunc();
    push_exp(4'b1011, 4'd4, 1'b1);
    push_exp(4'b1101, 4'd2, 1'b0);
    for (int i = 0; i < 6; i++) send_word(4'h1, i == 5);
    // limit and in_last on the same word is not a truncation
    push_exp(4'b0101, 4'd4, 1'b0);
    for (int i = 1; i <= 4; i++) send_word(4'(i), i == 4);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 10; p++) begin
      int len;
      len = int'($urandom_range(1, 7));
      for (int w = 0; w < len; w++) send_model(4'($urandom_range(0, 15)), w == len - 1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_exp(4'b1011, 4'd2, 1'b0);
    send_word(4'h2, 1'b0);
    send_word(4'h2, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'h5;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_sum, out_count, out_trunc} !== {1'b0, 1'b1, 4'hB, 4'd2, 1'b0}) begin
        errors++;
        $display("FAIL hold cycle %0d got rdy=%0b valid=%0b sum=%h cnt=%0d trunc=%0b expected 0 1 b 2 0",
                 i, in_ready, out_valid, out_sum, out_count, out_trunc);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_idle got rdy=%0b valid=%0b expected 1 0", in_ready, out_valid);
    end
    push_exp(4'b1010, 4'd1, 1'b0);
    send_word(4'h5, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    send_word(4'h4, 1'b0);
    send_word(4'h6, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_sum, out_count, in_ready} !== {1'b0, 4'hF, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got valid=%0b sum=%h cnt=%0d rdy=%0b expected 0 f 0 1",
               out_valid, out_sum, out_count, in_ready);
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_exp(4'b1000, 4'd1, 1'b0);
    send_word(4'h7, 1'b1);
    drain();
    // unconsumed result discarded by reset
    out_ready = 1'b0;
    send_word(4'h3, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_count !== 4'd0 || out_sum !== 4'hF) begin
      errors++;
      $display("FAIL reset_done got valid=%0b cnt=%0d sum=%h expected 0 0 f",
               out_valid, out_count, out_sum);
    end
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    push_exp(4'b1101, 4'd2, 1'b0);
    send_word(4'h1, 1'b0);
    send_word(4'h1, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_trunc();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ones_comp_checksum.md
ONES_COMP_CHECKSUM -- requirements
Module: ones_comp_checksum

Interface
REQ-001 Parameter: MAX_WORDS, default 15, maximum words per packet (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_data  input  4  operand word of the current packet.
REQ-005 Port: in_valid  input  1  in_data/in_last are valid this cycle.
REQ-006 Port: in_last  input  1  marks the final word of a packet.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: out_sum  output  4  one's-complement checksum (bitwise NOT of the end-around-carry sum).
REQ-009 Port: out_count  output  4  number of words folded into out_sum.
REQ-010 Port: out_trunc  output  1  packet was closed by MAX_WORDS, not by in_last.
REQ-011 Port: out_valid  output  1  out_sum/out_count/out_trunc hold a result.
REQ-012 Port: out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-013 A word SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; a result SHALL be consumed only on a rising edge where out_valid=1 and out_ready=1.
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and DONE, encoded in registers.
REQ-015 IDLE: in_ready=1, out_valid=0, acc=0, count=0; an accepted word loads acc=in_data and count=1; the next state is DONE if in_last=1 or MAX_WORDS=1, otherwise ACCUM.
REQ-016 ACCUM: in_ready=1, out_valid=0; each accepted word updates acc with the end-around add of REQ-019 and increments count.
REQ-017 ACCUM exit: when the accepted word has in_last=1, or the incremented count equals MAX_WORDS, the next state SHALL be DONE; with no accepted word, ACCUM SHALL hold.
REQ-018 DONE: in_ready=0, out_valid=1, out_sum=~acc, out_count=count; out_sum, out_count and out_trunc SHALL stay stable until consumed; on consumption the next state SHALL be IDLE.
REQ-019 End-around add: s = {1'b0,acc} + {1'b0,in_data} (5 bits); acc_next = s[3:0] + s[4], truncated to 4 bits. The second add SHALL never carry out, so no further wrap is required.
REQ-020 out_trunc SHALL be 1 when DONE is entered because count reached MAX_WORDS on a word with in_last=0, and 0 otherwise (including when in_last and the limit coincide).
REQ-021 After a truncated packet, following words SHALL start a new packet from IDLE; nothing SHALL be dropped or merged.
REQ-022 Latency: out_valid SHALL rise on the clock edge that accepts the final word, i.e. visible one cycle after that word is presented; throughput is one word per cycle in IDLE/ACCUM.
REQ-023 in_valid=1 while in_ready=0 (DONE) SHALL have no effect; upstream holds the word until accepted.
REQ-024 Outputs SHALL be driven only from registers or state decode, with no combinational path from in_* to out_*.
REQ-025 in_last in IDLE SHALL form a one-word packet: out_sum=~in_data, out_count=1.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, acc=0, count=0, out_trunc=0, out_valid=0 and out_sum=4'b1111.
REQ-027 in_ready SHALL be 1 during and after reset; out_count SHALL read 0.
REQ-028 Reset asserted mid-packet or in DONE SHALL discard partial or unconsumed results; the first word after release SHALL begin a fresh packet.

Verification
REQ-029 Words 3, 5 (last) with out_ready=1 -> one cycle later out_valid=1, out_sum=4'b0111, out_count=2, out_trunc=0.
REQ-030 Words A, B, C (last) -> acc 0110, then 0011 (end-around carries) -> out_sum=4'b1100, out_count=3.
REQ-031 Words F, 1 (last) -> out_sum=4'b1110; words 9, 8 (last) -> out_sum=4'b1101.
REQ-032 MAX_WORDS=4, six words of 1 with in_last only on the sixth -> first result out_sum=4'b1011, count=4, trunc=1; second result out_sum=4'b1101, count=2, trunc=0.
REQ-033 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no word accepted; out_ready=1 -> IDLE next cycle.
REQ-034 reset pulsed between clock edges after 2 words of a packet -> out_valid=0, out_sum=1111, count=0 immediately; packet 7 (last) afterwards -> out_sum=4'b1000, count=1.
